// File: rtl/lfsr_seq_checker_if.sv
// Control/status bundle between an LFSR sequence checker and the block that drives it.
// The controller side uses the master modport; the checker uses the slave modport.
interface lfsr_seq_checker_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             valid;
  logic [WIDTH-1:0] lfsr_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH:0]   period;
  logic [WIDTH:0]   visited;
  logic [1:0]       err;

  modport master (
    output start, valid, lfsr_in,
    input  busy, done, pass, period, visited, err
  );

  modport slave (
    input  start, valid, lfsr_in,
    output busy, done, pass, period, visited, err
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Measures the period of an LFSR stream, counts distinct states and flags lock-up or early repeats.
// Define LFSR_CHK_TIMEOUT_EN to fail a measurement after TIMEOUT consecutive cycles without a sample.
module lfsr_seq_checker #(
  parameter int WIDTH = 4
`ifdef LFSR_CHK_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input logic               CLK,
  input logic               reset,
  lfsr_seq_checker_if.slave bus
);

  localparam int NSTATES = 1 << WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  localparam logic [WIDTH:0]   CNT_MAX     = '1;
  localparam logic [WIDTH:0]   CNT_ONE     = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   FULL_PERIOD = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] ZERO_STATE  = '0;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LOCKUP  = 2'b01;
  localparam logic [1:0] ERR_REPEAT  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  logic [2:0]         state_q,   state_d;
  logic [NSTATES-1:0] bitmap_q,  bitmap_d;
  logic [WIDTH-1:0]   ref_q,     ref_d;
  logic [WIDTH:0]     period_q,  period_d;
  logic [WIDTH:0]     visited_q, visited_d;
  logic [1:0]         err_q,     err_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic               pass_q,    pass_d;

`ifdef LFSR_CHK_TIMEOUT_EN
  localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

  // Counters can never reach their ceiling while the bitmap guards against repeats.
  function automatic logic [WIDTH:0] sat_inc(input logic [WIDTH:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    state_d   = state_q;
    bitmap_d  = bitmap_q;
    ref_d     = ref_q;
    period_d  = period_q;
    visited_d = visited_q;
    err_d     = err_q;
    pass_d    = pass_q;
`ifdef LFSR_CHK_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
`endif

    if (bus.start) begin
      state_d   = S_ARM;
      bitmap_d  = '0;
      period_d  = '0;
      visited_d = '0;
      err_d     = ERR_NONE;
      pass_d    = 1'b0;
    end else begin
      case (state_q)
        S_ARM: begin
          if (bus.valid) begin
            if (bus.lfsr_in == ZERO_STATE) begin
              state_d = S_FAIL;
              err_d   = ERR_LOCKUP;
            end else begin
              state_d                = S_RUN;
              ref_d                  = bus.lfsr_in;
              bitmap_d[bus.lfsr_in]  = 1'b1;
              visited_d              = CNT_ONE;
            end
          end
        end
        S_RUN: begin
          if (bus.valid) begin
            period_d = sat_inc(period_q);
            if (bus.lfsr_in == ZERO_STATE) begin
              state_d = S_FAIL;
              err_d   = ERR_LOCKUP;
            end else if (bus.lfsr_in == ref_q) begin
              state_d = S_DONE;
              pass_d  = (period_d == FULL_PERIOD);
            end else if (bitmap_q[bus.lfsr_in]) begin
              state_d = S_FAIL;
              err_d   = ERR_REPEAT;
            end else begin
              bitmap_d[bus.lfsr_in] = 1'b1;
              visited_d             = sat_inc(visited_q);
            end
          end
        end
        default: ;
      endcase
    end

`ifdef LFSR_CHK_TIMEOUT_EN
    // Only an unbroken run of empty cycles while measuring counts towards the timeout.
    if (bus.start) begin
      idle_cnt_d = '0;
    end else if (state_q == S_ARM || state_q == S_RUN) begin
      if (bus.valid) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == IDLE_LAST) begin
        idle_cnt_d = '0;
        state_d    = S_FAIL;
        err_d      = ERR_TIMEOUT;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
`endif

    busy_d = (state_d == S_ARM)  || (state_d == S_RUN);
    done_d = (state_d == S_DONE) || (state_d == S_FAIL);
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use <= so every flop samples the pre-edge value of its neighbours.
    if (reset) begin
      state_q   <= S_IDLE;
      // NOTE: the visited-state bitmap is cleared by reset like ordinary flops; it is small and its
      // contents decide the repeat check, so it must never start from an unknown value.
      bitmap_q  <= '0;
      ref_q     <= '0;
      period_q  <= '0;
      visited_q <= '0;
      err_q     <= ERR_NONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef LFSR_CHK_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bitmap_q  <= bitmap_d;
      ref_q     <= ref_d;
      period_q  <= period_d;
      visited_q <= visited_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
`ifdef LFSR_CHK_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.period  = period_q;
  assign bus.visited = visited_q;
  assign bus.err     = err_q;

endmodule
